// File: rtl/alu_seq_md_pkg.sv
// Shared op codes, FSM states and flag bit order for the EX-stage ALU.
// Op classification helpers used by the top and its sub-module.
package alu_seq_md_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIVU  = 4'd12;
  localparam logic [3:0] OP_REMU  = 4'd13;
  localparam logic [3:0] OP_DIV   = 4'd14;
  localparam logic [3:0] OP_REM   = 4'd15;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_O = 1;
  localparam int FLAG_S = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_e;

  function automatic logic is_md(input logic [3:0] op);
    return op >= OP_MUL;
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return op >= OP_DIVU;
  endfunction

  function automatic logic is_sdiv(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem(input logic [3:0] op);
    return (op == OP_REMU) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_seq_md_comb.sv
// Single-cycle ALU ops 0-9 with ADD/SUB carry and overflow.
// Iterative op codes yield zero result and clear flags here.
import alu_seq_md_pkg::*;

module alu_seq_md_comb #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] res,
  output logic             cf,
  output logic             of
);

  localparam int SW = $clog2(WIDTH);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [SW-1:0]    sh;
  logic             slt;
  logic             sltu;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign dif  = {1'b0, a} - {1'b0, b};
  assign sh   = b[SW-1:0];
  assign slt  = $signed(a) < $signed(b);
  assign sltu = a < b;

  always_comb begin
    res = '0;
    cf  = 1'b0;
    of  = 1'b0;
    unique case (op)
      OP_ADD: begin
        res = sum[WIDTH-1:0];
        cf  = sum[WIDTH];
        of  = (a[WIDTH-1] == b[WIDTH-1]) &&
              (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res = dif[WIDTH-1:0];
        cf  = dif[WIDTH];
        of  = (a[WIDTH-1] != b[WIDTH-1]) &&
              (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SLL:  res = a << sh;
      OP_SRL:  res = a >> sh;
      OP_SRA:  res = $signed(a) >>> sh;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, slt};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, sltu};
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq_md.sv
// EX-stage execute unit: 1-cycle ALU plus iterative mul/div.
// Iterative path enabled by defining ALU_MULDIV_EN.
import alu_seq_md_pkg::*;

module alu_seq_md #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             ZF,
  output logic             CF,
  output logic             OF,
  output logic             SF
);

  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] ld_val;
  logic [3:0]       ld_flg;
  logic             cf;
  logic             of;
  logic             ld;
  logic             accept;

  alu_seq_md_comb #(.WIDTH(WIDTH)) u_comb (
    .a   (a),
    .b   (b),
    .op  (op),
    .res (res),
    .cf  (cf),
    .of  (of)
  );

  assign accept = in_valid & in_ready;

`ifdef ALU_MULDIV_EN
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN =
    {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;

  logic             sgn;
  logic             div0;
  logic             ovf;
  logic             special;
  logic             iter;
  logic             fix_go;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] spec_val;
  logic [WIDTH-1:0] fix_val;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] tdiff;
  logic             tge;

  assign sgn      = is_sdiv(op);
  assign div0     = (b == '0);
  assign ovf      = sgn & (a == MIN) & (&b);
  assign special  = is_div(op) & (div0 | ovf);
  assign iter     = is_md(op) & !special;
  assign spec_val = div0 ? (is_rem(op) ? a : '1)
                         : (is_rem(op) ? '0 : MIN);
  assign abs_a    = (sgn & a[WIDTH-1]) ? -a : a;
  assign abs_b    = (sgn & b[WIDTH-1]) ? -b : b;

  // Shift-add: multiplier in lo drains LSB-first, product fills acc:lo.
  assign msum  = {1'b0, acc} + (lo[0] ? {1'b0, mcand} : '0);
  // Restoring divide: remainder in acc, dividend/quotient in lo.
  assign trial = {acc, lo[WIDTH-1]};
  assign tge   = trial >= {1'b0, mcand};
  assign tdiff = trial[WIDTH-1:0] - mcand;

  assign in_ready = !rst & (state == ST_IDLE) &
                    (!out_valid | out_ready);
  assign fix_go   = (state == ST_FIX) &
                    (!out_valid | out_ready);

  always_comb begin
    fix_val = lo;
    unique case (op_q)
      OP_MULHU, OP_REMU: fix_val = acc;
      OP_DIV:  fix_val = neg_q ? -lo : lo;
      OP_REM:  fix_val = neg_r ? -acc : acc;
      default: fix_val = lo;
    endcase
  end

  always_comb begin
    ld     = 1'b0;
    ld_val = res;
    ld_flg = '0;
    if (fix_go) begin
      ld     = 1'b1;
      ld_val = fix_val;
    end else if (accept & !iter) begin
      ld             = 1'b1;
      ld_val         = special ? spec_val : res;
      ld_flg[FLAG_C] = cf;
      ld_flg[FLAG_O] = of;
    end
    ld_flg[FLAG_Z] = (ld_val == '0);
    ld_flg[FLAG_S] = ld_val[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      op_q  <= '0;
      acc   <= '0;
      lo    <= '0;
      mcand <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept & iter) begin
            op_q <= op;
            acc  <= '0;
            cnt  <= '0;
            if (is_div(op)) begin
              state <= ST_DIV;
              lo    <= abs_a;
              mcand <= abs_b;
              neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r <= sgn & a[WIDTH-1];
            end else begin
              state <= ST_MUL;
              lo    <= b;
              mcand <= a;
            end
          end
        end
        ST_MUL: begin
          acc <= msum[WIDTH:1];
          lo  <= {msum[0], lo[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (&cnt) state <= ST_FIX;
        end
        ST_DIV: begin
          acc <= tge ? tdiff : trial[WIDTH-1:0];
          lo  <= {lo[WIDTH-2:0], tge};
          cnt <= cnt + 1'b1;
          if (&cnt) state <= ST_FIX;
        end
        ST_FIX: begin
          if (fix_go) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  assign in_ready = !rst & (!out_valid | out_ready);

  always_comb begin
    ld             = accept;
    ld_val         = res;
    ld_flg         = '0;
    ld_flg[FLAG_C] = cf;
    ld_flg[FLAG_O] = of;
    ld_flg[FLAG_Z] = (res == '0);
    ld_flg[FLAG_S] = res[WIDTH-1];
  end
`endif

  // A new load wins over the handshake so results can stream 1/cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      ZF        <= 1'b0;
      CF        <= 1'b0;
      OF        <= 1'b0;
      SF        <= 1'b0;
    end else if (ld) begin
      out_valid <= 1'b1;
      out       <= ld_val;
      ZF        <= ld_flg[FLAG_Z];
      CF        <= ld_flg[FLAG_C];
      OF        <= ld_flg[FLAG_O];
      SF        <= ld_flg[FLAG_S];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq_md.sv
// Self-checking bench for alu_seq_md (WIDTH=32), directed + random ops.
// Works with ALU_MULDIV_EN defined or undefined.
module tb_alu_seq_md;

`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        ZF, CF, OF, SF;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] last_out;
  logic [3:0]  last_flg;
  int          last_lat;

  alu_seq_md #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .ZF        (ZF),
    .CF        (CF),
    .OF        (OF),
    .SF        (SF)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit oflow(input longint v);
    return (v > 64'sd2147483647) || (v < -64'sd2147483648);
  endfunction

  // Reference model straight from the op definitions.
  function automatic void model(input logic [3:0] o,
                                input logic [31:0] x, y,
                                output logic [31:0] r,
                                output logic c, v,
                                output int lat);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    p  = 64'(ux) * 64'(uy);
    r = '0; c = 1'b0; v = 1'b0; lat = 1;
    case (o)
      4'd0: begin
        r = 32'(ux + uy);
        c = (ux + uy) > 64'sd4294967295;
        v = oflow(sx + sy);
      end
      4'd1: begin
        r = x - y;
        c = x < y;
        v = oflow(sx - sy);
      end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = x << y[4:0];
      4'd6: r = x >> y[4:0];
      4'd7: r = 32'(sx >>> y[4:0]);
      4'd8: r = {31'b0, sx < sy};
      4'd9: r = {31'b0, ux < uy};
      4'd10: r = p[31:0];
      4'd11: r = p[63:32];
      4'd12: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      4'd13: r = (y == 0) ? x : x % y;
      4'd14: r = (y == 0) ? 32'hFFFF_FFFF : 32'(sx / sy);
      default: r = (y == 0) ? x : 32'(sx % sy);
    endcase
    if (o >= 4'd10) begin
      if (!MD) r = '0;
      else if (o < 4'd12) lat = 34;
      else if (y == 0) lat = 1;
      else if (o >= 4'd14 && x == MIN && y == 32'hFFFF_FFFF) lat = 1;
      else lat = 34;
    end
  endfunction

  // Issue one op with out_ready=1 and check result, flags, latency.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, y);
    logic [31:0] er;
    logic ec, ev;
    int elat, lat, guard, busy;
    string t;
    t = $sformatf("op%0d_%h_%h", o, x, y);
    model(o, x, y, er, ec, ev, elat);
    op = o; a = x; b = y; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    chk({t, "_acc"}, 64'(guard >= 100), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; busy = 0;
    while (!out_valid && lat < 80) begin
      if (in_ready) busy++;
      @(posedge clk); #1; lat++;
    end
    chk({t, "_lat"}, 64'(lat), 64'(elat));
    chk({t, "_out"}, 64'(out), 64'(er));
    chk({t, "_flg"}, {60'd0, ZF, CF, OF, SF},
        {60'd0, er == 0, ec, ev, er[31]});
    if (elat > 1) chk({t, "_busy"}, 64'(busy), 64'd0);
    last_out = out;
    last_flg = {ZF, CF, OF, SF};
    last_lat = lat;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return MIN;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    logic [31:0] er;
    logic ec, ev;
    int el;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_flg", {60'd0, ZF, CF, OF, SF}, 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready", 64'(in_ready), 64'd1);

    run_op(4'd0, 32'hFFFF_FFFF, 32'h1);
    chk("add_wrap_out", 64'(last_out), 64'h0);
    chk("add_wrap_flg", 64'(last_flg), 64'b1100);
    chk("add_wrap_lat", 64'(last_lat), 64'd1);
    run_op(4'd1, MIN, 32'h1);
    chk("sub_ovf_out", 64'(last_out), 64'h7FFF_FFFF);
    chk("sub_ovf_flg", 64'(last_flg), 64'b0010);
    run_op(4'd0, 32'd3, 32'd5);
    chk("add_3_5", 64'(last_out), 64'd8);

`ifdef ALU_MULDIV_EN
    run_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mul_out", 64'(last_out), 64'h1);
    chk("mul_lat", 64'(last_lat), 64'd34);
    run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mulhu_out", 64'(last_out), 64'hFFFF_FFFE);
    run_op(4'd14, 32'hFFFF_FFF9, 32'h2);
    chk("div_neg", 64'(last_out), 64'hFFFF_FFFD);
    chk("div_neg_sf", 64'(last_flg[0]), 64'd1);
    run_op(4'd15, 32'hFFFF_FFF9, 32'h2);
    chk("rem_neg", 64'(last_out), 64'hFFFF_FFFF);
    run_op(4'd12, 32'h7, 32'h0);
    chk("divu0_out", 64'(last_out), 64'hFFFF_FFFF);
    chk("divu0_lat", 64'(last_lat), 64'd1);
    run_op(4'd14, MIN, 32'hFFFF_FFFF);
    chk("div_ovf_out", 64'(last_out), 64'(MIN));
    chk("div_ovf_lat", 64'(last_lat), 64'd1);
`else
    run_op(4'd10, 32'd3, 32'd5);
    chk("nomd_mul_out", 64'(last_out), 64'd0);
    chk("nomd_mul_zf", 64'(last_flg), 64'b1000);
    chk("nomd_mul_lat", 64'(last_lat), 64'd1);
`endif

    // Back-to-back single-cycle ops.
    op = 4'd4; a = 32'hF0F0_1234; b = 32'h0FF0_FFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b_xor", 64'(out), 64'hFF00_EDCB);
    chk("b2b_xor_v", 64'(out_valid), 64'd1);
    op = 4'd7; a = MIN; b = 32'd4;
    @(posedge clk); #1;
    chk("b2b_sra", 64'(out), 64'hF800_0000);
    chk("b2b_sra_v", 64'(out_valid), 64'd1);
    op = 4'd9; a = 32'd1; b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("b2b_sltu", 64'(out), 64'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_drain", 64'(out_valid), 64'd0);

    // Backpressure: result and flags hold while out_ready is low.
    out_ready = 1'b0;
    model(4'd1, 32'd5, 32'd9, er, ec, ev, el);
    op = 4'd1; a = 32'd5; b = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_out%0d", i), {out_valid, out}, {1'b1, er});
      chk($sformatf("bp_flg%0d", i), {60'd0, ZF, CF, OF, SF},
          {60'd0, 1'b0, ec, ev, er[31]});
      chk($sformatf("bp_rdy%0d", i), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 64'(out_valid), 64'd0);

    // Reset while a divide is in flight discards it.
    op = 4'd14; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_rdy", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("mid_rel_rdy", 64'(in_ready), 64'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("mid_rst_discard", 64'(seen), 64'd0);

    // Random ops against the model.
    for (int i = 0; i < 80; i++) begin
      run_op(4'($urandom_range(0, 15)), pick(), pick());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
